// File: rtl/writeback_retire.sv
// Memory-to-writeback pipeline register and retire controller for the my86 pipeline.
// Drives the W-stage register-file write port, tracks processor status and halts on the first fault.
module writeback_retire #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       m_stat_i,
  input  logic [3:0]       M_icode_i,
  input  logic [3:0]       M_dstE_i,
  input  logic [3:0]       M_dstM_i,
  input  logic [63:0]      M_valE_i,
  input  logic [63:0]      m_valM_i,
  input  logic             W_stall_i,
  input  logic             W_bubble_i,
  output logic [2:0]       W_stat_o,
  output logic [3:0]       W_icode_o,
  output logic [3:0]       W_dstE_o,
  output logic [3:0]       W_dstM_o,
  output logic [63:0]      W_valE_o,
  output logic [63:0]      W_valM_o,
  output logic             halted_o,
  output logic [2:0]       stat_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] retired_cnt_o
);

  localparam logic [2:0]       SAOK    = 3'd1;
  localparam logic [3:0]       INOP    = 4'h1;
  localparam logic [3:0]       RNONE   = 4'hF;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state_r, state_s;
  logic [2:0]  w_stat_r, w_stat_s;
  logic [3:0]  w_icode_r, w_icode_s;
  logic [3:0]  w_dste_r, w_dste_s;
  logic [3:0]  w_dstm_r, w_dstm_s;
  logic [63:0] w_vale_r, w_vale_s;
  logic [63:0] w_valm_r, w_valm_s;
  logic        w_valid_r, w_valid_s;
  logic        count_s;
  logic        retire_s;
  logic [CNT_W-1:0] cycle_cnt_r;
  logic [CNT_W-1:0] retired_cnt_r;
  logic        block_write_s;

  // Next-state and W-register update; a faulting stat in W freezes everything from this edge on.
  always_comb begin
    state_s   = state_r;
    w_stat_s  = w_stat_r;
    w_icode_s = w_icode_r;
    w_dste_s  = w_dste_r;
    w_dstm_s  = w_dstm_r;
    w_vale_s  = w_vale_r;
    w_valm_s  = w_valm_r;
    w_valid_s = w_valid_r;
    count_s   = 1'b0;
    retire_s  = 1'b0;
    case (state_r)
      RUN: begin
        count_s  = 1'b1;
        // Counted as it leaves W, so a stalled instruction retires only once.
        retire_s = w_valid_r && (w_stat_r == SAOK) && !W_stall_i;
        if (w_stat_r != SAOK) begin
          state_s = HALTED;
        end else if (W_stall_i) begin
          state_s = RUN;
        end else if (W_bubble_i) begin
          w_stat_s  = SAOK;
          w_icode_s = INOP;
          w_dste_s  = RNONE;
          w_dstm_s  = RNONE;
          w_vale_s  = 64'd0;
          w_valm_s  = 64'd0;
          w_valid_s = 1'b0;
        end else begin
          w_stat_s  = m_stat_i;
          w_icode_s = M_icode_i;
          w_dste_s  = M_dstE_i;
          w_dstm_s  = M_dstM_i;
          w_vale_s  = M_valE_i;
          w_valm_s  = m_valM_i;
          w_valid_s = 1'b1;
        end
      end
      HALTED: begin
        state_s = HALTED;
      end
      default: begin
        state_s = RUN;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // W pipeline register and counters; reset loads the bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_stat_r      <= SAOK;
      w_icode_r     <= INOP;
      w_dste_r      <= RNONE;
      w_dstm_r      <= RNONE;
      w_vale_r      <= 64'd0;
      w_valm_r      <= 64'd0;
      w_valid_r     <= 1'b0;
      cycle_cnt_r   <= '0;
      retired_cnt_r <= '0;
    end else begin
      w_stat_r  <= w_stat_s;
      w_icode_r <= w_icode_s;
      w_dste_r  <= w_dste_s;
      w_dstm_r  <= w_dstm_s;
      w_vale_r  <= w_vale_s;
      w_valm_r  <= w_valm_s;
      w_valid_r <= w_valid_s;
      if (count_s) begin
        cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
      end
      if (retire_s) begin
        retired_cnt_r <= retired_cnt_r + CNT_ONE;
      end
    end
  end

  // Write addresses are suppressed combinationally so a faulting instruction never writes.
  assign block_write_s = (state_r == HALTED) || (w_stat_r != SAOK);
  assign W_dstE_o      = block_write_s ? RNONE : w_dste_r;
  assign W_dstM_o      = block_write_s ? RNONE : w_dstm_r;
  assign W_stat_o      = w_stat_r;
  assign W_icode_o     = w_icode_r;
  assign W_valE_o      = w_vale_r;
  assign W_valM_o      = w_valm_r;
  assign halted_o      = (state_r == HALTED);
  assign stat_o        = w_valid_r ? w_stat_r : SAOK;
  assign cycle_cnt_o   = cycle_cnt_r;
  assign retired_cnt_o = retired_cnt_r;

endmodule

// File: doc/writeback_retire.md
# writeback_retire

Memory-to-writeback pipeline register and retire controller for the my86 five-stage pipeline. Captures memory-stage results each cycle and drives the W-stage write port (dstE/valE, dstM/valM) consumed by the decode stage's register file and forwarding network. It also holds the processor status and halts the machine on the first non-AOK status reaching W. It keeps cycle and retired-instruction counters.

## Interface
Parameters:
- CNT_W, 32, width of cycle and retire counters.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- m_stat_i  in  3  memory-stage status: SAOK=1, SHLT=2, SADR=3, SINS=4.
- M_icode_i  in  4  memory-stage icode.
- M_dstE_i  in  4  E destination; RNONE=4'hF.
- M_dstM_i  in  4  M destination; RNONE=4'hF.
- M_valE_i  in  64  ALU result.
- m_valM_i  in  64  memory read data.
- W_stall_i  in  1  hold W register.
- W_bubble_i  in  1  load bubble into W register.
- W_stat_o  out  3  status of instruction in W.
- W_icode_o  out  4  icode in W.
- W_dstE_o  out  4  gated E write address to register file/forwarding.
- W_dstM_o  out  4  gated M write address.
- W_valE_o  out  64  E write data.
- W_valM_o  out  64  M write data.
- halted_o  out  1  machine halted.
- stat_o  out  3  processor status.
- cycle_cnt_o  out  CNT_W  cycles since reset while running.
- retired_cnt_o  out  CNT_W  instructions retired with SAOK.

## Operation
- Internal W register: stat, icode, dstE, dstM, valE, valM, valid.
- Bubble contents: stat=SAOK, icode=INOP (4'h1), dstE=dstM=RNONE, valE=valM=0, valid=0.
- FSM states: RUN, HALTED.
- RUN, per edge, with priority:
  - W_stall_i=1: hold the register. Stall wins over a simultaneous bubble.
  - W_bubble_i=1: load bubble contents.
  - Otherwise: capture the M inputs with valid=1.
- RUN -> HALTED on the edge where the held W_stat != SAOK.
- In HALTED:
  - Register frozen.
  - Stall, bubble and M inputs ignored.
  - Counters frozen.
  - Exit only by reset.
- Write gating (combinational):
  - W_dstE_o = RNONE if halted_o or W_stat != SAOK, else the held dstE.
  - W_dstM_o follows the same rule.
  - valE/valM always pass through ungated.
- stat_o = held W_stat, except a bubble reports SAOK. In HALTED it stays at the exception code (SHLT/SADR/SINS).
- Retire rule:
  - retired_cnt increments by 1 on an edge where state=RUN, valid=1, W_stat=SAOK and W_stall_i=0. Counting at departure means a stalled instruction is counted once.
  - Halt and faulting instructions are never counted.
- cycle_cnt increments on every RUN edge.
- Counters wrap modulo 2^CNT_W without flag.
- Reset values:
  - W register = bubble.
  - W_dstE_o=W_dstM_o=4'hF, W_stat_o=stat_o=SAOK, W_icode_o=4'h1, vals=0.
  - halted_o=0, both counters 0, state RUN.

## Timing
- M inputs appear on W_* outputs one cycle after capture edge (registered).
- Gated dst outputs react combinationally to the held stat: a faulting instruction never presents a valid write address, even in its first W cycle.
- halted_o asserts one cycle after the faulting instruction first appears on W_stat_o.
- Counters are registered. retired_cnt_o reflects an instruction the cycle after it leaves W.
- Reset mid-operation (including in HALTED): next cycle all outputs at reset values, state RUN, regardless of stall/bubble.

## Test plan
- Reset, then capture OPQ (icode 6, dstE=3, valE=0x55, stat SAOK) -> next cycle W_dstE_o=3, W_valE_o=0x55, W_dstM_o=F. One edge later retired_cnt_o=1.
- Hold the same instruction with W_stall_i=1 for 3 cycles, then release -> outputs constant during the stall; retired_cnt_o increments exactly once.
- W_stall_i=W_bubble_i=1 together -> register held (stall wins). W_bubble_i alone -> W_icode_o=1, dsts=F, stat_o=SAOK, retired count unchanged.
- Capture a popq with m_stat_i=SADR, dstM=2 -> W_dstM_o=F immediately, halted_o=1 next cycle, stat_o=3. Later M inputs ignored and counters frozen.
- Capture halt (SHLT) followed by a valid OPQ -> the OPQ is never captured, stat_o=2, retired_cnt excludes halt. Then rst_i=1 for 1 cycle -> all reset values, halted_o=0.
- Preload near wrap (run 2^CNT_W-1 cycles with CNT_W=8 override) -> cycle_cnt_o goes 255 -> 0.
